alu_arbiter: RTL and testbench

Shares one combinational 16-bit `alu` instance between `N_REQ` requesters (issue stage, address-generation unit, debug port).
- Requests use a valid/ready handshake; each cycle the arbiter picks one and applies its operands and command to the ALU.
- The result is captured in a single registered output stage, tagged with the requester index.
- Sits between the requesting pipeline stages and the shared ALU datapath.

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu.sv | 35 +++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: command encodings, command type,
// default datapath width and the requester-tag width helper.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 16;

  typedef logic [2:0] alu_cmd_t;

  localparam alu_cmd_t ALU_ADD = 3'b000;
  localparam alu_cmd_t ALU_SUB = 3'b001;
  localparam alu_cmd_t ALU_AND = 3'b010;
  localparam alu_cmd_t ALU_OR  = 3'b011;
  localparam alu_cmd_t ALU_XOR = 3'b100;
  localparam alu_cmd_t ALU_SL  = 3'b101;
  localparam alu_cmd_t ALU_SR  = 3'b110;
  localparam alu_cmd_t ALU_SRU = 3'b111;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath. Shifts use the low log2(WIDTH) bits of i_b;
// SR is arithmetic, SRU is logical.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_cmd_t         i_cmd,
  output logic [WIDTH-1:0] o_r
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] w_sh;

  assign w_sh = i_b[SH_W-1:0];

  always_comb begin
    o_r = '0;
    case (i_cmd)
      ALU_ADD: o_r = i_a + i_b;
      ALU_SUB: o_r = i_a - i_b;
      ALU_AND: o_r = i_a & i_b;
      ALU_OR:  o_r = i_a | i_b;
      ALU_XOR: o_r = i_a ^ i_b;
      ALU_SL:  o_r = i_a << w_sh;
      ALU_SR:  o_r = WIDTH'($signed(i_a) >>> w_sh);
      ALU_SRU: o_r = i_a >> w_sh;
      default: o_r = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters, with a single
// registered result stage. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int N_REQ = 2,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_cmd,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_r
);

  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_r;

  logic             w_can_accept;
  logic             w_grant_found;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_req_xfer;
  logic [N_REQ-1:0] w_ready;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  alu_cmd_t         w_alu_cmd;
  logic [WIDTH-1:0] w_alu_r;

  // Gated with rst_n so no requester sees a grant while reset is held.
  assign w_can_accept = rst_n && (!r_rsp_valid || rsp_ready);
  assign w_req_xfer   = w_grant_found && w_can_accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_grant_found = 1'b1;
        w_grant_id    = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_grant_found && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_grant_found = 1'b1;
        w_grant_id    = ID_W'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_req_xfer) begin
      r_ptr <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end
  end
`endif

  always_comb begin
    w_ready             = '0;
    w_ready[w_grant_id] = w_req_xfer;
  end

  assign req_ready = w_ready;
  assign w_alu_a   = req_a[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_alu_b   = req_b[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_alu_cmd = req_cmd[int'(w_grant_id)*3 +: 3];

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a   (w_alu_a),
    .i_b   (w_alu_b),
    .i_cmd (w_alu_cmd),
    .o_r   (w_alu_r)
  );

  // Result and tag hold their last value once the response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_r     <= '0;
    end else if (w_req_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_id;
      r_rsp_r     <= w_alu_r;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_r     = r_rsp_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N_REQ=2, WIDTH=16).
// Expectations follow the fixed-priority build when ALU_ARB_FIXED_PRIO_EN is defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_cmd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_r;

  int n_checks;
  int n_fail;

  alu_arbiter #(.WIDTH(16), .N_REQ(2), .ID_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cmd   (req_cmd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input alu_cmd_t cmd);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_cmd[i*3 +: 3] = cmd;
  endtask

  task automatic set_rr_payload();
    set_req(0, 16'h8000, 16'h0004, ALU_SR);
    set_req(1, 16'h0003, 16'h0005, ALU_SUB);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    set_rr_payload();
    #2;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_r !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_r: got %h exp 0000", rsp_r); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b exp 0", rsp_id); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_edge_rsp_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_edge_req_ready: got %b exp 00", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    set_req(0, 16'h0005, 16'h0003, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_req_ready: got %b exp 01", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp_valid: got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_r !== 16'h0008) begin n_fail++; $display("FAIL add_rsp_r: got %h exp 0008", rsp_r); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL add_rsp_id: got %b exp 0", rsp_id); end
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_r !== 16'h0008) begin n_fail++; $display("FAIL add_hold_r: got %h exp 0008", rsp_r); end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  cmds [8];
    logic [15:0] exps [8];
    cmds = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SL, ALU_SR, ALU_SRU};
    exps = '{16'h9327, 16'h9141, 16'h0030, 16'h92F7, 16'h92C7, 16'h91A0, 16'hF246, 16'h1246};
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_req(1, 16'h9234, 16'h00F3, cmds[i]);
      req_valid = 2'b10;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_r !== exps[i] || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_op_%0d: got r=%h id=%b v=%b exp r=%h id=1 v=1", i, rsp_r, rsp_id, rsp_valid, exps[i]);
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_round_robin();
    logic       exp_g;
    logic [1:0] exp_rdy;
    logic [15:0] exp_r;
    apply_reset();
    set_rr_payload();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      exp_rdy = exp_g ? 2'b10 : 2'b01;
      exp_r   = exp_g ? 16'hFFFE : 16'hF800;
      #1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready_%0d: got %b exp %b", i, req_ready, exp_rdy); end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_r !== exp_r || rsp_id !== exp_g || rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_rsp_%0d: got r=%h id=%b v=%b exp r=%h id=%b v=1", i, rsp_r, rsp_id, rsp_valid, exp_r, exp_g);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    set_rr_payload();
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_first_ready: got %b exp 10", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_r !== 16'hFFFE || rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_first_rsp: got r=%h id=%b exp r=fffe id=1", rsp_r, rsp_id); end
    @(negedge clk);
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready_%0d: got %b exp 00", i, req_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (rsp_r !== 16'hFFFE || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got r=%h id=%b v=%b exp r=fffe id=1 v=1", i, rsp_r, rsp_id, rsp_valid);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 01", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_r !== 16'hF800 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_release_rsp: got r=%h id=%b exp r=f800 id=0", rsp_r, rsp_id); end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_ready: got %b exp 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_r !== 16'hFFFE || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got r=%h id=%b v=%b exp r=fffe id=1 v=0", rsp_r, rsp_id, rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_rr_payload();
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b exp 1", rsp_valid); end
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_cleared: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_r !== 16'h0000) begin n_fail++; $display("FAIL ar_r_cleared: got %h exp 0000", rsp_r); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ar_first_grant: got %b exp 01", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_r !== 16'hF800 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL ar_first_rsp: got r=%h id=%b exp r=f800 id=0", rsp_r, rsp_id); end
    @(negedge clk);
    req_valid = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_rdy;
    apply_reset();
    set_rr_payload();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = i[0] ? 2'b10 : 2'b01;
`endif
      #1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL prio_ready_%0d: got %b exp %b", i, req_ready, exp_rdy); end
      @(negedge clk);
    end
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL prio_req1_ready: got %b exp 10", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rsp_r !== 16'hFFFE || rsp_id !== 1'b1) begin n_fail++; $display("FAIL prio_req1_rsp: got r=%h id=%b exp r=fffe id=1", rsp_r, rsp_id); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cmd   = '0;
    test_reset();
    test_single_add();
    test_alu_ops();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_fixed_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
